// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-port RAM arbiter.
//  DW/AW       : RAM word and address widths
//  PORT_*      : port identifiers used as the read-return tag
//  RD_LAT      : RAM read latency in cycles, grant to read data
//  ram_cmd_t   : one RAM access (write enable, address, write data)
package ram_arb_pkg;

    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 12;
    localparam int unsigned RD_LAT = 1;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_LSU    = 1'b1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ram_cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with same-cycle combinational grant.
//  clk, rst : clock, asynchronous active-high reset
//  req[1:0] : requests, bit 0 = port0, bit 1 = port1
//  gnt[1:0] : one-hot grant (or zero), forced low during reset
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 1 = port1 won the most recent grant; resets to 1 so port0 wins the first tie.
    logic r_last_gnt;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = r_last_gnt ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Remember the winner only on cycles that actually grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
        end else if (|gnt) begin
            r_last_gnt <= gnt[1];
        end
    end

endmodule

// File: rtl/single_port_ram.sv
// Behavioural single-port RAM with a registered read (one cycle latency).
//  clk  : clock
//  we   : write enable, write at rising edge
//  addr : word address
//  data : write data
//  q    : read data for the address presented on the previous edge
module single_port_ram #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] q
);

    logic [DW-1:0] r_mem [2**AW];

    // Read-before-write on the same address returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= data;
        end
        q <= r_mem[addr];
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between instruction fetch (port0) and the
// load/store unit (port1): round-robin grant, one access per cycle, read
// data returned with a per-port valid RD_LAT cycles after the grant.
//  clk, rst                  : clock, asynchronous active-high reset
//  reqN/weN/addrN/wdataN     : port N request, held until gntN
//  gntN                      : port N accepted this cycle (combinational)
//  rvalidN/rdataN            : port N read return
//  ram_we/ram_addr/ram_data  : RAM command (combinational, zero when idle)
//  ram_q                     : RAM read data
module ram_port_arbiter
    import ram_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_q
);

    logic [1:0] w_gnt;
    ram_cmd_t   w_cmd;
    logic       w_win;
    logic       w_rd_start;

    // Read-return pipeline: pend marks an outstanding read, tag its port.
    logic [RD_LAT-1:0] r_rd_pend;
    logic [RD_LAT-1:0] r_rd_tag;

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({req1, req0}),
        .gnt (w_gnt)
    );

    assign gnt0  = w_gnt[0];
    assign gnt1  = w_gnt[1];
    assign w_win = w_gnt[1] ? PORT_LSU : PORT_IFETCH;

    // RAM-side mux; the bus is driven to zero when nobody is granted.
    always_comb begin
        w_cmd = '0;
        if (w_gnt[0]) begin
            w_cmd = '{we: we0, addr: addr0, data: wdata0};
        end else if (w_gnt[1]) begin
            w_cmd = '{we: we1, addr: addr1, data: wdata1};
        end
    end

    assign ram_we     = w_cmd.we;
    assign ram_addr   = w_cmd.addr;
    assign ram_data   = w_cmd.data;
    assign w_rd_start = (|w_gnt) & ~w_cmd.we;

    // Async reset drops any read in flight, suppressing its rvalid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend <= '0;
            r_rd_tag  <= '0;
        end else begin
            r_rd_pend <= (r_rd_pend << 1) | RD_LAT'(w_rd_start);
            r_rd_tag  <= (r_rd_tag << 1) | RD_LAT'(w_win);
        end
    end

    assign rvalid0 = r_rd_pend[RD_LAT-1] & (r_rd_tag[RD_LAT-1] == PORT_IFETCH);
    assign rvalid1 = r_rd_pend[RD_LAT-1] & (r_rd_tag[RD_LAT-1] == PORT_LSU);

    // Read data is broadcast; only meaningful alongside the matching rvalid.
    assign rdata0 = ram_q;
    assign rdata1 = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter with a behavioural RAM behind it.
// Directed scenarios followed by a randomized two-requester run, all
// compared cycle by cycle against a transaction-level reference model.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [11:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_data, ram_q;

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents, last winner, and the one read in flight.
    logic [31:0] m_mem [int];
    int          m_last = 1;
    bit          m_pend = 1'b0;
    int          m_pend_port = 0;
    logic [31:0] m_pend_data = '0;
    int          g_win = -1;

    always #50 clk = ~clk;

    ram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_q(ram_q)
    );

    single_port_ram #(.DW(32), .AW(12)) u_ram (
        .clk(clk), .we(ram_we), .addr(ram_addr), .data(ram_data), .q(ram_q)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic drive0(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d);
        req0 = r; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d);
        req1 = r; we1 = w; addr1 = a; wdata1 = d;
    endtask

    // One cycle: called just after a falling edge with inputs already driven.
    task automatic step(input string tag);
        int          win;
        logic        e_we;
        logic [11:0] e_addr;
        logic [31:0] e_data;
        bit          e_rv0, e_rv1;
        #1;
        win = -1;
        if (!rst) begin
            if (req0 && req1) win = (m_last == 1) ? 0 : 1;
            else if (req0)    win = 0;
            else if (req1)    win = 1;
        end
        e_we = 1'b0; e_addr = '0; e_data = '0;
        if (win == 0) begin e_we = we0; e_addr = addr0; e_data = wdata0; end
        if (win == 1) begin e_we = we1; e_addr = addr1; e_data = wdata1; end
        e_rv0 = !rst && m_pend && (m_pend_port == 0);
        e_rv1 = !rst && m_pend && (m_pend_port == 1);

        chk($sformatf("%s.gnt0", tag), 32'(gnt0), 32'(win == 0));
        chk($sformatf("%s.gnt1", tag), 32'(gnt1), 32'(win == 1));
        chk($sformatf("%s.ram_we", tag), 32'(ram_we), 32'(e_we));
        chk($sformatf("%s.ram_addr", tag), 32'(ram_addr), 32'(e_addr));
        chk($sformatf("%s.ram_data", tag), ram_data, e_data);
        chk($sformatf("%s.rvalid0", tag), 32'(rvalid0), 32'(e_rv0));
        chk($sformatf("%s.rvalid1", tag), 32'(rvalid1), 32'(e_rv1));
        if (e_rv0) chk($sformatf("%s.rdata0", tag), rdata0, m_pend_data);
        if (e_rv1) chk($sformatf("%s.rdata1", tag), rdata1, m_pend_data);

        @(posedge clk);
        g_win = win;
        m_pend = 1'b0;
        if (rst) begin
            m_last = 1;
        end else if (win >= 0) begin
            m_last = win;
            if (e_we) begin
                m_mem[int'(e_addr)] = e_data;
            end else begin
                m_pend      = 1'b1;
                m_pend_port = win;
                m_pend_data = m_mem.exists(int'(e_addr)) ? m_mem[int'(e_addr)] : 32'h0;
            end
        end
        @(negedge clk);
    endtask

    bit          p_act [2];
    logic        p_we [2];
    logic [11:0] p_addr [2];
    logic [31:0] p_data [2];

    initial begin
        // Reset pulse for two cycles; grants and rvalids must stay low.
        #5 rst = 1'b1;
        @(negedge clk);
        drive0(1'b1, 1'b0, 12'h0, 32'h0);
        drive1(1'b1, 1'b0, 12'h1, 32'h0);
        step("rst0");
        step("rst1");
        rst = 1'b0;
        drive0(1'b0, 1'b0, 12'h0, 32'h0);
        drive1(1'b0, 1'b0, 12'h0, 32'h0);
        step("post_rst");

        // Single port: writes then reads on port0 only.
        for (int i = 0; i < 3; i++) begin
            drive0(1'b1, 1'b1, 12'(i), 32'(i + 1));
            step($sformatf("sp_wr%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            drive0(1'b1, 1'b0, 12'(i), 32'h0);
            step($sformatf("sp_rd%0d", i));
        end
        drive0(1'b0, 1'b0, 12'h0, 32'h0);
        step("sp_tail");
        chk("sp.mem2", m_pend_data, 32'h3);

        // Preload 0xA/0xB and the rest of the low addresses used later.
        drive0(1'b1, 1'b1, 12'h0, 32'hA);
        step("pre_a");
        drive0(1'b0, 1'b0, 12'h0, 32'h0);
        for (int i = 1; i < 8; i++) begin
            drive1(1'b1, 1'b1, 12'(i), (i == 1) ? 32'hB : 32'($urandom));
            step($sformatf("pre%0d", i));
        end
        drive1(1'b0, 1'b0, 12'h0, 32'h0);
        step("pre_idle");

        // Contention: both read continuously; expect 0,1,0,1 starting at port0.
        drive0(1'b1, 1'b0, 12'h0, 32'h0);
        drive1(1'b1, 1'b0, 12'h1, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step($sformatf("cont%0d", i));
            chk($sformatf("cont%0d.order", i), 32'(g_win), 32'(i % 2));
        end
        drive0(1'b0, 1'b0, 12'h0, 32'h0);
        drive1(1'b0, 1'b0, 12'h0, 32'h0);
        step("cont_tail");

        // Read-after-write at the top of the address space.
        drive1(1'b1, 1'b1, 12'hFFF, 32'hDEADBEEF);
        step("raw_wr");
        drive1(1'b0, 1'b0, 12'h0, 32'h0);
        drive0(1'b1, 1'b0, 12'hFFF, 32'h0);
        step("raw_rd");
        drive0(1'b0, 1'b0, 12'h0, 32'h0);
        step("raw_ret");
        chk("raw.data", m_pend_data, 32'hDEADBEEF);

        // Idle: three empty cycles, then a tie goes to the other port (port1).
        for (int i = 0; i < 3; i++) step($sformatf("idle%0d", i));
        drive0(1'b1, 1'b0, 12'h2, 32'h0);
        drive1(1'b1, 1'b0, 12'h3, 32'h0);
        step("idle_tie");
        chk("idle_tie.win", 32'(g_win), 32'd1);
        drive0(1'b0, 1'b0, 12'h0, 32'h0);
        drive1(1'b0, 1'b0, 12'h0, 32'h0);
        step("idle_tail");

        // Reset the cycle after a port1 read grant; its rvalid must never appear.
        drive1(1'b1, 1'b0, 12'h4, 32'h0);
        step("mr_gnt");
        drive1(1'b0, 1'b0, 12'h0, 32'h0);
        rst = 1'b1;
        step("mr_rst0");
        step("mr_rst1");
        rst = 1'b0;
        drive0(1'b1, 1'b0, 12'h5, 32'h0);
        drive1(1'b1, 1'b0, 12'h6, 32'h0);
        step("mr_tie");
        chk("mr_tie.win", 32'(g_win), 32'd0);
        drive0(1'b0, 1'b0, 12'h0, 32'h0);
        drive1(1'b0, 1'b0, 12'h0, 32'h0);
        step("mr_tail");

        // Randomized traffic: each requester holds its request until granted.
        for (int p = 0; p < 2; p++) p_act[p] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_act[p] && $urandom_range(0, 3) != 0) begin
                    p_act[p]  = 1'b1;
                    p_we[p]   = 1'($urandom_range(0, 1));
                    p_addr[p] = ($urandom_range(0, 8) == 8) ? 12'hFFF : 12'($urandom_range(0, 7));
                    p_data[p] = $urandom;
                end
            end
            drive0(p_act[0], p_we[0], p_addr[0], p_data[0]);
            drive1(p_act[1], p_we[1], p_addr[1], p_data[1]);
            step($sformatf("rnd%0d", c));
            if (g_win >= 0) p_act[g_win] = 1'b0;
        end
        drive0(1'b0, 1'b0, 12'h0, 32'h0);
        drive1(1'b0, 1'b0, 12'h0, 32'h0);
        step("rnd_tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
